// File: rtl/collision_matrix.sv
// collision_matrix: N-by-M per-pixel collision detector.
// Each frame, an object pulses at most once, on the cycle after its first hit.
// The block also keeps a saturating count of A-hits for the current frame.
module collision_matrix #(
  parameter int NUM_A         = 4,
  parameter int NUM_B         = 8,
  parameter int ONE_HIT_PER_B = 1,
  parameter int COUNT_W       = 4
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               enable,
  input  logic [NUM_A-1:0]   a_req,
  input  logic [NUM_B-1:0]   b_req,
  output logic [NUM_A-1:0]   a_hit_pulse,
  output logic [NUM_B-1:0]   b_hit_pulse,
  output logic               any_hit_pulse,
  output logic [NUM_A-1:0]   a_hit_frame,
  output logic [COUNT_W-1:0] frame_hit_count,
  output logic [COUNT_W-1:0] last_frame_hits
);

  localparam int PC_W  = $clog2(NUM_A + 1);
  // Wide enough for count + popcount even if NUM_A is large relative to COUNT_W.
  localparam int SUM_W = ((COUNT_W + 1) > PC_W) ? (COUNT_W + 1) : (PC_W + 1);
  localparam logic [SUM_W-1:0] MAX_SUM = SUM_W'((1 << COUNT_W) - 1);

  logic [NUM_A-1:0]   r_a_flag;
  logic [NUM_B-1:0]   r_b_flag;
  logic [NUM_A-1:0]   r_a_hit_pulse;
  logic [NUM_B-1:0]   r_b_hit_pulse;
  logic               r_any_hit_pulse;
  logic [COUNT_W-1:0] r_frame_hit_count;
  logic [COUNT_W-1:0] r_last_frame_hits;

  logic [NUM_A-1:0]   w_a_flag_eff;
  logic [NUM_B-1:0]   w_b_flag_eff;
  logic [NUM_B-1:0]   w_b_elig;
  logic [NUM_A-1:0]   w_coll_a;
  logic [NUM_B-1:0]   w_coll_b;
  logic [NUM_A-1:0]   w_new_a;
  logic [NUM_B-1:0]   w_new_b;
  logic [PC_W-1:0]    w_popcount;
  logic [SUM_W-1:0]   w_sum;
  logic [COUNT_W-1:0] w_count_next;

  // The strobe pixel belongs to the new frame, so it sees already-cleared flags.
  assign w_a_flag_eff = startOfFrame ? '0 : r_a_flag;
  assign w_b_flag_eff = startOfFrame ? '0 : r_b_flag;

  // With consumption enabled, a B object that already hit this frame can no longer collide.
  assign w_b_elig = (ONE_HIT_PER_B != 0) ? (b_req & ~w_b_flag_eff) : b_req;

  assign w_coll_a = a_req & {NUM_A{|w_b_elig}};
  assign w_coll_b = w_b_elig & {NUM_B{|a_req}};

  assign w_new_a = {NUM_A{enable}} & w_coll_a & ~w_a_flag_eff;
  assign w_new_b = {NUM_B{enable}} & w_coll_b & ~w_b_flag_eff;

  // Count the A objects that got their first hit this cycle.
  always_comb begin
    w_popcount = '0;
    for (int i = 0; i < NUM_A; i++) begin
      w_popcount = w_popcount + PC_W'(w_new_a[i]);
    end
  end

  // Add the new hits to the running count, or start from zero on the strobe, then saturate.
  always_comb begin
    w_sum = (startOfFrame ? '0 : SUM_W'(r_frame_hit_count)) + SUM_W'(w_popcount);
    if (w_sum > MAX_SUM) begin
      w_count_next = MAX_SUM[COUNT_W-1:0];
    end else begin
      w_count_next = w_sum[COUNT_W-1:0];
    end
  end

  // Register the pulses, the per-frame flags and the counters.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_a_flag          <= '0;
      r_b_flag          <= '0;
      r_a_hit_pulse     <= '0;
      r_b_hit_pulse     <= '0;
      r_any_hit_pulse   <= 1'b0;
      r_frame_hit_count <= '0;
      r_last_frame_hits <= '0;
    end else begin
      r_a_flag          <= w_a_flag_eff | w_new_a;
      r_b_flag          <= w_b_flag_eff | w_new_b;
      r_a_hit_pulse     <= w_new_a;
      r_b_hit_pulse     <= w_new_b;
      r_any_hit_pulse   <= |w_new_a;
      r_frame_hit_count <= w_count_next;
      if (startOfFrame) begin
        r_last_frame_hits <= r_frame_hit_count;
      end
    end
  end

  assign a_hit_pulse     = r_a_hit_pulse;
  assign b_hit_pulse     = r_b_hit_pulse;
  assign any_hit_pulse   = r_any_hit_pulse;
  assign a_hit_frame     = r_a_flag;
  assign frame_hit_count = r_frame_hit_count;
  assign last_frame_hits = r_last_frame_hits;

endmodule

// File: tb/tb_collision_matrix.sv
// Testbench for collision_matrix. It runs two instances on the same stimulus.
// Instance 0 consumes each B object after its hit and has a 4-bit counter.
// Instance 1 never consumes B objects and has a 2-bit saturating counter.
module tb_collision_matrix;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame;
  logic       enable;
  logic [3:0] a_req;
  logic [7:0] b_req;

  logic [3:0] a_pulse0, a_frame0, a_pulse1, a_frame1;
  logic [7:0] b_pulse0, b_pulse1;
  logic       any0, any1;
  logic [3:0] cnt0, last0;
  logic [1:0] cnt1, last1;

  int checks   = 0;
  int failures = 0;

  // Reference state, indexed by instance: per-object "already hit this frame" flags.
  bit         m_a_flag [2][4];
  bit         m_b_flag [2][8];
  int         m_count  [2];
  int         m_last   [2];
  logic [3:0] e_a_pulse[2];
  logic [7:0] e_b_pulse[2];
  logic       e_any    [2];

  always #5 clk = ~clk;

  collision_matrix #(.NUM_A(4), .NUM_B(8), .ONE_HIT_PER_B(1), .COUNT_W(4)) dut0 (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable),
    .a_req(a_req), .b_req(b_req),
    .a_hit_pulse(a_pulse0), .b_hit_pulse(b_pulse0), .any_hit_pulse(any0),
    .a_hit_frame(a_frame0), .frame_hit_count(cnt0), .last_frame_hits(last0)
  );

  collision_matrix #(.NUM_A(4), .NUM_B(8), .ONE_HIT_PER_B(0), .COUNT_W(2)) dut1 (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable),
    .a_req(a_req), .b_req(b_req),
    .a_hit_pulse(a_pulse1), .b_hit_pulse(b_pulse1), .any_hit_pulse(any1),
    .a_hit_frame(a_frame1), .frame_hit_count(cnt1), .last_frame_hits(last1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one clock cycle of the game's rules to one instance.
  // An object hits when it overlaps any object of the other group. A B object that
  // has been consumed is treated as absent. Nothing hits twice in the same frame.
  task automatic model_step(input int k, input bit consume, input int cmax);
    bit fa[4];
    bit fb[8];
    bit elig[8];
    bit any_b;
    bit any_a;
    int hits;
    if (!resetN) begin
      for (int i = 0; i < 4; i++) m_a_flag[k][i] = 0;
      for (int j = 0; j < 8; j++) m_b_flag[k][j] = 0;
      m_count[k] = 0; m_last[k] = 0;
      e_a_pulse[k] = '0; e_b_pulse[k] = '0; e_any[k] = 1'b0;
      return;
    end
    for (int i = 0; i < 4; i++) fa[i] = startOfFrame ? 1'b0 : m_a_flag[k][i];
    for (int j = 0; j < 8; j++) fb[j] = startOfFrame ? 1'b0 : m_b_flag[k][j];
    any_b = 0;
    for (int j = 0; j < 8; j++) begin
      elig[j] = b_req[j] && !(consume && fb[j]);
      if (elig[j]) any_b = 1;
    end
    any_a = (a_req != 0);
    hits = 0;
    e_a_pulse[k] = '0;
    e_b_pulse[k] = '0;
    for (int i = 0; i < 4; i++) begin
      if (enable && a_req[i] && any_b && !fa[i]) begin
        e_a_pulse[k][i] = 1'b1;
        hits++;
        fa[i] = 1;
      end
    end
    for (int j = 0; j < 8; j++) begin
      if (enable && elig[j] && any_a && !fb[j]) begin
        e_b_pulse[k][j] = 1'b1;
        fb[j] = 1;
      end
    end
    e_any[k] = (hits > 0);
    if (startOfFrame) begin
      m_last[k]  = m_count[k];
      m_count[k] = 0;
    end
    m_count[k] = (m_count[k] + hits > cmax) ? cmax : m_count[k] + hits;
    for (int i = 0; i < 4; i++) m_a_flag[k][i] = fa[i];
    for (int j = 0; j < 8; j++) m_b_flag[k][j] = fb[j];
  endtask

  function automatic logic [3:0] pack_a(input int k);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_a_flag[k][i];
    return v;
  endfunction

  task automatic compare_all();
    chk("a_pulse0", 32'(a_pulse0), 32'(e_a_pulse[0]));
    chk("b_pulse0", 32'(b_pulse0), 32'(e_b_pulse[0]));
    chk("any0",     32'(any0),     32'(e_any[0]));
    chk("a_frame0", 32'(a_frame0), 32'(pack_a(0)));
    chk("cnt0",     32'(cnt0),     32'(m_count[0]));
    chk("last0",    32'(last0),    32'(m_last[0]));
    chk("a_pulse1", 32'(a_pulse1), 32'(e_a_pulse[1]));
    chk("b_pulse1", 32'(b_pulse1), 32'(e_b_pulse[1]));
    chk("any1",     32'(any1),     32'(e_any[1]));
    chk("a_frame1", 32'(a_frame1), 32'(pack_a(1)));
    chk("cnt1",     32'(cnt1),     32'(m_count[1]));
    chk("last1",    32'(last1),    32'(m_last[1]));
  endtask

  // Drive one cycle of inputs, advance the reference across the edge, then check just after the edge.
  task automatic step(input logic [3:0] a, input logic [7:0] b, input logic sof,
                      input logic en, input logic rst_n);
    a_req = a; b_req = b; startOfFrame = sof; enable = en; resetN = rst_n;
    @(posedge clk);
    model_step(0, 1'b1, 15);
    model_step(1, 1'b0, 3);
    #1;
    compare_all();
  endtask

  initial begin
    a_req = '0; b_req = '0; startOfFrame = 1'b0; enable = 1'b1; resetN = 1'b0;

    // Reset
    repeat (3) step(4'h0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("reset_cnt0", 32'(cnt0), 32'd0);
    chk("reset_a_frame0", 32'(a_frame0), 32'd0);
    step(4'h0, 8'h00, 1'b1, 1'b1, 1'b1);

    // A1 and B0 overlap for 20 cycles. Each pulses once, on the cycle after the first overlap.
    step(4'b0010, 8'h01, 1'b0, 1'b1, 1'b1);
    chk("first_a_pulse", 32'(a_pulse0), 32'h2);
    chk("first_b_pulse", 32'(b_pulse0), 32'h1);
    repeat (19) step(4'b0010, 8'h01, 1'b0, 1'b1, 1'b1);
    chk("no_repeat_pulse", 32'(a_pulse0), 32'h0);
    chk("a_hit_frame1", 32'(a_frame0[1]), 32'd1);

    // The next frame pulses again, and the previous frame's count is latched.
    step(4'h0, 8'h00, 1'b1, 1'b1, 1'b1);
    chk("last_frame_1", 32'(last0), 32'd1);
    step(4'b0010, 8'h01, 1'b0, 1'b1, 1'b1);
    chk("second_frame_pulse", 32'(a_pulse0), 32'h2);

    // B0 hits A0, then overlaps A2. Instance 0 consumed B0, so A2 does not pulse; instance 1 pulses A2.
    step(4'h0, 8'h00, 1'b1, 1'b1, 1'b1);
    step(4'b0001, 8'h01, 1'b0, 1'b1, 1'b1);
    step(4'b0100, 8'h01, 1'b0, 1'b1, 1'b1);
    chk("consumed_no_a2", 32'(a_pulse0), 32'h0);
    chk("unconsumed_a2", 32'(a_pulse1), 32'h4);
    chk("unconsumed_b0_once", 32'(b_pulse1), 32'h0);

    // All four A overlap B0 and B1 in the same cycle.
    step(4'h0, 8'h00, 1'b1, 1'b1, 1'b1);
    step(4'b1111, 8'h03, 1'b0, 1'b1, 1'b1);
    chk("all_a_pulse", 32'(a_pulse0), 32'hF);
    chk("both_b_pulse", 32'(b_pulse0), 32'h03);
    chk("count4", 32'(cnt0), 32'd4);
    chk("sat_count", 32'(cnt1), 32'd3);
    step(4'b0001, 8'h04, 1'b1, 1'b1, 1'b1);
    chk("sat_latched", 32'(last1), 32'd3);

    // An overlap while disabled does not pulse. An overlap on the strobe cycle counts in the new frame.
    step(4'b0100, 8'h10, 1'b0, 1'b0, 1'b1);
    chk("disabled_no_pulse", 32'(a_pulse0), 32'h0);
    step(4'b1000, 8'h20, 1'b1, 1'b1, 1'b1);
    chk("sof_coincident_cnt", 32'(cnt0), 32'd1);
    // Reset in the middle of a frame
    step(4'b0001, 8'h40, 1'b0, 1'b1, 1'b1);
    step(4'b0011, 8'h40, 1'b0, 1'b1, 1'b0);
    chk("midreset_cnt", 32'(cnt0), 32'd0);
    step(4'b0010, 8'h80, 1'b0, 1'b1, 1'b1);
    chk("post_reset_pulse", 32'(a_pulse0), 32'h2);

    // Random stimulus with sparse requests, occasional frame strobes, disables and resets.
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] ra;
      logic [7:0] rb;
      ra = 4'($urandom) & 4'($urandom);
      rb = 8'($urandom) & 8'($urandom) & 8'($urandom);
      step(ra, rb, ($urandom_range(0, 29) == 0), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 199) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
